glip_traffic_engine: RTL

GLIP_TRAFFIC_ENGINE -- requirements
Module: glip_traffic_engine

---
 rtl/glip_traffic_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/glip_traffic_engine.sv
// GLIP host traffic engine: loopback FIFO, counting generator, sequence checker
// and an input-throughput meter sharing one valid/ready host port pair.
module glip_traffic_engine #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int FREQ  = 60000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      err_count,
    output logic [31:0]      bytes_per_win,
    output logic             win_done
);

    // Handshake: a beat happens when valid && ready; a raised valid holds its
    // data stable until the beat. No output depends combinationally on in_data.

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam int WIN_W = (FREQ > 1) ? $clog2(FREQ) : 1;
    localparam int BYTES = WIDTH / 8;

    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(FREQ - 1);

    typedef enum logic [1:0] {
        MODE_LOOP   = 2'b00,
        MODE_GEN    = 2'b01,
        MODE_CHK    = 2'b10,
        MODE_GENCHK = 2'b11
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] gen_cnt_q, gen_cnt_d;
    logic [WIDTH-1:0] exp_cnt_q, exp_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [31:0]      beat_cnt_q, beat_cnt_d;
    logic [31:0]      bytes_q, bytes_d;
    logic             win_done_q, win_done_d;

    logic switch_cyc, active, loop_mode, gen_mode, chk_mode;
    logic fifo_full, fifo_empty, in_beat, out_beat, push, pop, win_last;
    logic [31:0] beat_sum;

    always_comb begin
        mode_d     = mode_e'(mode);
        switch_cyc = (mode_d != mode_q);
        active     = !rst && !switch_cyc;
        loop_mode  = (mode_q == MODE_LOOP);
        gen_mode   = (mode_q == MODE_GEN) || (mode_q == MODE_GENCHK);
        chk_mode   = (mode_q == MODE_CHK) || (mode_q == MODE_GENCHK);
        fifo_full  = (cnt_q == FULL_CNT);
        fifo_empty = (cnt_q == '0);

        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        if (active) begin
            if (loop_mode) begin
                in_ready  = !fifo_full;
                out_valid = !fifo_empty;
                out_data  = mem_q[rd_ptr_q];
            end else begin
                in_ready = 1'b1;
                if (gen_mode) begin
                    out_valid = 1'b1;
                    out_data  = gen_cnt_q;
                end
            end
        end

        in_beat  = in_valid && in_ready;
        out_beat = out_valid && out_ready;
        push     = in_beat && loop_mode;
        pop      = out_beat && loop_mode;

        // Register views are held at zero for the whole reset cycle, not just after it.
        err_count     = rst ? 16'd0 : err_cnt_q;
        bytes_per_win = rst ? 32'd0 : bytes_q;
        win_done      = rst ? 1'b0  : win_done_q;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        gen_cnt_d = gen_cnt_q;
        exp_cnt_d = exp_cnt_q;
        err_cnt_d = err_cnt_q;

        if (switch_cyc) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            gen_cnt_d = '0;
            exp_cnt_d = '0;
        end else begin
            if (gen_mode && out_beat) begin
                gen_cnt_d = gen_cnt_q + WIDTH'(1);
            end
            if (chk_mode && in_beat) begin
                // A mismatch resynchronises onto the received value.
                exp_cnt_d = in_data + WIDTH'(1);
                if ((in_data != exp_cnt_q) && (err_cnt_q != 16'hFFFF)) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        win_last   = (win_cnt_q == WIN_LAST);
        win_cnt_d  = win_last ? '0 : win_cnt_q + WIN_W'(1);
        beat_sum   = (in_beat && (beat_cnt_q != 32'hFFFF_FFFF)) ? beat_cnt_q + 32'd1 : beat_cnt_q;
        beat_cnt_d = beat_sum;
        bytes_d    = bytes_q;
        win_done_d = 1'b0;
        if (win_last) begin
            bytes_d    = beat_sum * 32'(BYTES);
            beat_cnt_d = '0;
            win_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mode_q <= mode_d;
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            gen_cnt_q  <= '0;
            exp_cnt_q  <= '0;
            err_cnt_q  <= '0;
            win_cnt_q  <= '0;
            beat_cnt_q <= '0;
            bytes_q    <= '0;
            win_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            gen_cnt_q  <= gen_cnt_d;
            exp_cnt_q  <= exp_cnt_d;
            err_cnt_q  <= err_cnt_d;
            win_cnt_q  <= win_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            bytes_q    <= bytes_d;
            win_done_q <= win_done_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
